seq_detect_prog: RTL and testbench

Runtime-programmable serial bit-pattern detector: the parametrised successor to the team's fixed-pattern Moore sequence detectors. It compares a qualified serial bit stream against a loaded pattern of 1..N bits. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits between the serial front-end (bit + valid) and control logic that needs a registered one-cycle match pulse.

---
 rtl/seq_detect_prog.sv | 126 ++++++++++++
 tb/tb_seq_detect_prog.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: matches the last cfg_len accepted
// bits against a loaded pattern, with overlap/non-overlap modes and a saturating count.
module seq_detect_prog #(
    parameter  int N     = 8,
    parameter  int CNT_W = 8,
    localparam int LW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err,
    output logic             armed
);

    typedef enum logic {
        S_UNCFG = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [LW-1:0] N_L = LW'(N);

    state_t           state_q, state_d;
    logic [N-1:0]     pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [N-1:0]     len_mask;
    logic [N-1:0]     hist_shift;
    logic [LW-1:0]    fill_inc;
    logic             cfg_legal;
    logic             match;

    // Only the low len_q bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < N; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
    end

    assign hist_shift = {hist_q[N-2:0], x};
    assign fill_inc   = (fill_q == N_L) ? fill_q : fill_q + LW'(1);
    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= N_L);
    assign match      = (((hist_shift ^ pat_q) & len_mask) == '0) && (fill_inc >= len_q);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        y_d     = 1'b0;
        err_d   = 1'b0;

        // A load, legal or not, always wins over a bit presented on the same cycle.
        if (cfg_load) begin
            if (cfg_legal) begin
                state_d = S_RUN;
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                cnt_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == S_RUN && in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match) begin
                y_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign y           = y_q;
    assign match_count = cnt_q;
    assign cfg_err     = err_q;
    assign armed       = (state_q == S_RUN);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: a default-width instance and a 2-bit-counter instance
// share one directed stream; each cycle's expected outputs are queued and checked.
module tb_seq_detect_prog;

    localparam int N  = 8;
    localparam int LW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_load = 1'b0;
    logic [N-1:0]  cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          in_valid = 1'b0;
    logic          x = 1'b0;

    logic          y, cfg_err, armed;
    logic [7:0]    match_count;
    logic          y_s, err_s, armed_s;
    logic [1:0]    cnt_s;

    // Expected record: {y, cfg_err, armed, match_count[7:0]}
    logic [10:0]   exp_q[$];
    logic [10:0]   e;
    logic [1:0]    sat;
    int            checks = 0;
    int            failures = 0;
    int            cyc_n = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.N(N), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .y(y), .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
    );

    seq_detect_prog #(.N(N), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .y(y_s), .match_count(cnt_s), .cfg_err(err_s), .armed(armed_s)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, act, req);
        end
    endtask

    // Monitor: outputs are registered, so sample on the falling edge.
    always @(negedge clk) begin
        cyc_n++;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            sat = (e[7:0] > 8'd3) ? 2'd3 : e[1:0];
            chk("y",           {7'b0, y},       {7'b0, e[10]});
            chk("cfg_err",     {7'b0, cfg_err}, {7'b0, e[9]});
            chk("armed",       {7'b0, armed},   {7'b0, e[8]});
            chk("match_count", match_count,     e[7:0]);
            chk("sat_y",       {7'b0, y_s},     {7'b0, e[10]});
            chk("sat_err",     {7'b0, err_s},   {7'b0, e[9]});
            chk("sat_armed",   {7'b0, armed_s}, {7'b0, e[8]});
            chk("sat_count",   {6'b0, cnt_s},   {6'b0, sat});
        end
    end

    task automatic cyc(input logic rst_n, input logic ld, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic v, input logic xb,
                       input logic ey, input logic eerr, input logic earm,
                       input logic [7:0] ecnt);
        reset       = rst_n;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = v;
        x           = xb;
        @(posedge clk);
        exp_q.push_back({ey, eerr, earm, ecnt});
        @(negedge clk);
    endtask

    task automatic rst1();
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic ld(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic eerr, input logic earm, input logic [7:0] ecnt);
        cyc(1'b1, 1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, eerr, earm, ecnt);
    endtask

    task automatic bt(input logic v, input logic xb, input logic ey, input logic earm,
                      input logic [7:0] ecnt);
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, v, xb, ey, 1'b0, earm, ecnt);
    endtask

    initial begin
        rst1();
        rst1();
        bt(1, 1, 0, 0, 0);

        // Illegal loads from UNCFG
        ld(8'h00, 4'd0, 1'b0, 1, 0, 0);
        for (int i = 0; i < 4; i++) bt(1, 1, 0, 0, 0);
        ld(8'hFF, 4'd9, 1'b1, 1, 0, 0);
        bt(0, 0, 0, 0, 0);

        // Overlap, pattern 1001 len 4: matches after bits 4 and 7
        ld(8'b1001, 4'd4, 1'b1, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
        bt(1, 0, 0, 1, 1); bt(1, 0, 0, 1, 1); bt(1, 1, 1, 1, 2);
        bt(0, 1, 0, 1, 2);
        // Illegal load while running keeps config, history and count
        ld(8'h00, 4'd0, 1'b0, 1, 1, 2);
        bt(1, 0, 0, 1, 2); bt(1, 0, 0, 1, 2); bt(1, 1, 1, 1, 3);

        // Non-overlap: single match on the same stream
        ld(8'b1001, 4'd4, 1'b0, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
        bt(1, 0, 0, 1, 1); bt(1, 0, 0, 1, 1); bt(1, 1, 0, 1, 1);

        // Bubbles between bits (x=1 on bubbles must be ignored)
        ld(8'b1001, 4'd4, 1'b1, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(0, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(0, 1, 0, 1, 0);
        bt(0, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(0, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
        bt(0, 1, 0, 1, 1);

        // Reconfigure mid-stream discards partial history
        bt(1, 1, 0, 1, 1); bt(1, 0, 0, 1, 1); bt(1, 0, 0, 1, 1);
        ld(8'b1001, 4'd4, 1'b1, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);

        // Load with in_valid=1 drops the bit: 1(dropped),0,0,1 must not match
        cyc(1'b1, 1'b1, 8'b1001, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 0, 1, 0);

        // len=1 back-to-back matches and counter saturation on the 2-bit instance
        ld(8'hA5, 4'd1, 1'b1, 0, 1, 0);
        for (int i = 1; i <= 6; i++) bt(1, 1, 1, 1, 8'(i));
        bt(1, 0, 0, 1, 6);

        // Full-length pattern len=N, non-overlap
        ld(8'b1011_0010, 4'd8, 1'b0, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 0, 1, 0); bt(1, 1, 0, 1, 0);
        bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 0, 1, 0); bt(1, 0, 1, 1, 1);

        // Reset mid-stream, with reset winning over a coincident load and bit
        ld(8'b1001, 4'd4, 1'b1, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0);
        cyc(1'b0, 1'b1, 8'b1001, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        bt(1, 1, 0, 0, 0);
        ld(8'b1001, 4'd4, 1'b1, 0, 1, 0);
        bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
        bt(0, 0, 0, 1, 1);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
